alu_share_arb: RTL



---
 rtl/alu_share_arb_if.sv | 24 ++
 rtl/alu_share_arb.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
// Requester-side request/response handshake bundle for alu_share_arb.
interface alu_share_arb_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*4-1:0]    req_op;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [31:0]          resp_c;
    logic                 resp_cout;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_c, resp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_c, resp_cout
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module alu_share_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arb_if.slave     bus,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [3:0]         alu_op,
    input  logic [31:0]        alu_c,
    input  logic               alu_cout,
    output logic               busy,
    output logic [IDXW-1:0]    grant_idx
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state;
    logic              win_found;
    logic [IDXW-1:0]   win_idx;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [3:0]        sel_op;
    int                rank;
    int                best_rank;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0]   last;
`endif

    // Winner = valid requester with the smallest distance from the priority start.
    always_comb begin : arbitrate
        win_found = 1'b0;
        win_idx   = '0;
        best_rank = int'(NREQ);
        rank      = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
            rank = i;
`else
            rank = (i + int'(NREQ) - 1 - int'(last)) % int'(NREQ);
`endif
            if (bus.req_valid[i] && (rank < best_rank)) begin
                best_rank = rank;
                win_found = 1'b1;
                win_idx   = IDXW'(i);
            end
        end
    end

    // Operand mux and the combinational accept pulse, only offered in IDLE.
    always_comb begin : select
        sel_a         = '0;
        sel_b         = '0;
        sel_op        = '0;
        bus.req_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDXW'(i) == win_idx) begin
                sel_a            = bus.req_a[i*32 +: 32];
                sel_b            = bus.req_b[i*32 +: 32];
                sel_op           = bus.req_op[i*4 +: 4];
                bus.req_ready[i] = win_found && (state == IDLE) && !rst;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : fsm
        if (rst) begin
            state          <= IDLE;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            bus.resp_c     <= '0;
            bus.resp_cout  <= 1'b0;
            bus.resp_valid <= '0;
            busy           <= 1'b0;
            grant_idx      <= '0;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
            last           <= IDXW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        alu_a     <= sel_a;
                        alu_b     <= sel_b;
                        alu_op    <= sel_op;
                        grant_idx <= win_idx;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
                        last      <= win_idx;
`endif
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Branch compares (1110/1111) only yield Cout; C is meaningless.
                    bus.resp_c    <= (alu_op[3:1] == 3'b111) ? 32'd0 : alu_c;
                    bus.resp_cout <= alu_cout;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        bus.resp_valid[i] <= (IDXW'(i) == grant_idx);
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (|(bus.resp_valid & bus.resp_ready)) begin
                        bus.resp_valid <= '0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
